// File: rtl/coin_seq_pkg.sv
// coin_seq_pkg: shared types and default timing for the coin/start sequencer.
//   seq_state_e : sequencer states (IDLE, COIN_ON, GAP, START_ON, COOLDOWN)
//   P1 / P2     : player encoding stored in the pending slot and player latch
//   DEF_*       : default frame counts and counter width
package coin_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COIN_ON  = 3'd1,
        GAP      = 3'd2,
        START_ON = 3'd3,
        COOLDOWN = 3'd4
    } seq_state_e;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    localparam int DEF_COIN_FRAMES     = 4;
    localparam int DEF_GAP_FRAMES      = 8;
    localparam int DEF_START_FRAMES    = 4;
    localparam int DEF_COOLDOWN_FRAMES = 30;
    localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/frame_tick.sv
// frame_tick: one-cycle frame tick on the rising edge of vertical blank.
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   vblank in  vertical blank from the video core, clk domain
//   tick   out high for one cycle when vblank rises
module frame_tick (
    input  logic clk,
    input  logic rst,
    input  logic vblank,
    output logic tick
);

    logic vblank_q;

    // Reset value 1: a vblank already high when reset releases is not a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblank_q <= 1'b1;
        end else begin
            vblank_q <= vblank;
        end
    end

    assign tick = vblank & ~vblank_q;

endmodule

// File: rtl/coin_start_seq.sv
// coin_start_seq: turns a 1P/2P start request into a frame-timed sequence of
// coin pulse(s), settle gap and start pulse for the arcade core.
//   CLK       in  system clock
//   RESET     in  asynchronous active-high reset
//   I_VBLANK  in  core vertical blank; rising edge = frame tick
//   I_START1  in  1P start request (level)
//   I_START2  in  2P start request (level)
//   I_COIN    in  manual coin (level), OR'd into O_COIN
//   O_COIN    out coin to core, active-high
//   O_START1  out 1P start to core, active-high
//   O_START2  out 2P start to core, active-high
//   O_BUSY    out high whenever the sequencer is not idle
//   DBG_STATE out current sequencer state, for observation only
// Requests are single-cycle pulses taken from the rising edge of a start
// input; there is no backpressure, a request that finds the pending slot
// full is simply dropped.
module coin_start_seq
    import coin_seq_pkg::*;
#(
    parameter int COIN_FRAMES     = DEF_COIN_FRAMES,
    parameter int GAP_FRAMES      = DEF_GAP_FRAMES,
    parameter int START_FRAMES    = DEF_START_FRAMES,
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       I_VBLANK,
    input  logic       I_START1,
    input  logic       I_START2,
    input  logic       I_COIN,
    output logic       O_COIN,
    output logic       O_START1,
    output logic       O_START2,
    output logic       O_BUSY,
    output seq_state_e DBG_STATE
);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LD_COIN   = CNT_W'(COIN_FRAMES);
    localparam logic [CNT_W-1:0] LD_GAP    = CNT_W'(GAP_FRAMES);
    localparam logic [CNT_W-1:0] LD_START  = CNT_W'(START_FRAMES);
    localparam logic [CNT_W-1:0] LD_COOL   = CNT_W'(COOLDOWN_FRAMES);

    logic tick;

    frame_tick u_frame_tick (
        .clk    (CLK),
        .rst    (RESET),
        .vblank (I_VBLANK),
        .tick   (tick)
    );

    // Start edge detection. The copies reset to 1 so a button held through
    // reset cannot fire; the edge itself is registered, giving two cycles
    // from the input rising to O_COIN.
    logic start1_q, start2_q;
    logic req1_q, req2_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            start1_q <= 1'b1;
            start2_q <= 1'b1;
            req1_q   <= 1'b0;
            req2_q   <= 1'b0;
        end else begin
            start1_q <= I_START1;
            start2_q <= I_START2;
            req1_q   <= I_START1 & ~start1_q;
            req2_q   <= I_START2 & ~start2_q;
        end
    end

    logic req_any;
    logic req_player;

    assign req_any    = req1_q | req2_q;
    assign req_player = req2_q ? P2 : P1;   // simultaneous requests go to 2P

    seq_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       coins_left, coins_left_n;
    logic             player, player_n;
    logic             pend_valid, pend_valid_n;
    logic             pend_player, pend_player_n;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            cnt         <= '0;
            coins_left  <= 2'd0;
            player      <= P1;
            pend_valid  <= 1'b0;
            pend_player <= P1;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            coins_left  <= coins_left_n;
            player      <= player_n;
            pend_valid  <= pend_valid_n;
            pend_player <= pend_player_n;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        coins_left_n  = coins_left;
        player_n      = player;
        pend_valid_n  = pend_valid;
        pend_player_n = pend_player;

        case (state)
            IDLE: begin
                // A request parked during the previous sequence wins over a
                // fresh one arriving in the same cycle; the fresh one drops.
                if (pend_valid || req_any) begin
                    player_n     = pend_valid ? pend_player : req_player;
                    pend_valid_n = 1'b0;
                    coins_left_n = (player_n == P2) ? 2'd2 : 2'd1;
                    state_n      = COIN_ON;
                    cnt_n        = LD_COIN;
                end
            end
            COIN_ON: begin
                if (tick) begin
                    if (cnt == CNT_ONE) begin
                        coins_left_n = coins_left - 2'd1;
                        state_n      = GAP;
                        cnt_n        = LD_GAP;
                    end else begin
                        cnt_n = cnt - CNT_ONE;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (cnt == CNT_ONE) begin
                        if (coins_left != 2'd0) begin
                            state_n = COIN_ON;
                            cnt_n   = LD_COIN;
                        end else begin
                            state_n = START_ON;
                            cnt_n   = LD_START;
                        end
                    end else begin
                        cnt_n = cnt - CNT_ONE;
                    end
                end
            end
            START_ON: begin
                if (tick) begin
                    if (cnt == CNT_ONE) begin
                        state_n = COOLDOWN;
                        cnt_n   = LD_COOL;
                    end else begin
                        cnt_n = cnt - CNT_ONE;
                    end
                end
            end
            COOLDOWN: begin
                if (tick) begin
                    if (cnt == CNT_ONE) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt - CNT_ONE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // While busy, the first request is parked; later ones are dropped.
        if (state != IDLE && req_any && !pend_valid) begin
            pend_valid_n  = 1'b1;
            pend_player_n = req_player;
        end
    end

    // Outputs are registered from the next state so they change together with
    // the state register. The I_COIN term passes through this one register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            O_COIN   <= 1'b0;
            O_START1 <= 1'b0;
            O_START2 <= 1'b0;
        end else begin
            O_COIN   <= (state_n == COIN_ON) | I_COIN;
            O_START1 <= (state_n == START_ON) && (player_n == P1);
            O_START2 <= (state_n == START_ON) && (player_n == P2);
        end
    end

    assign O_BUSY    = (state != IDLE);
    assign DBG_STATE = state;

endmodule

// File: tb/tb_coin_start_seq.sv
module tb_coin_start_seq;
    import coin_seq_pkg::*;

    localparam int C_F  = 4;
    localparam int G_F  = 8;
    localparam int S_F  = 4;
    localparam int CD_F = 30;
    localparam int MAXN = 10000;
    localparam int BIG  = 1 << 28;

    // observed/expected vector bit positions
    localparam int B_COIN = 3;
    localparam int B_S1   = 2;
    localparam int B_S2   = 1;
    localparam int B_BUSY = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vb = 1'b0, s1 = 1'b0, s2 = 1'b0, ci = 1'b0;
    logic       o_coin, o_s1, o_s2, o_busy;
    seq_state_e dbg;

    coin_start_seq #(
        .COIN_FRAMES     (C_F),
        .GAP_FRAMES      (G_F),
        .START_FRAMES    (S_F),
        .COOLDOWN_FRAMES (CD_F),
        .CNT_W           (8)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .I_VBLANK  (vb),
        .I_START1  (s1),
        .I_START2  (s2),
        .I_COIN    (ci),
        .O_COIN    (o_coin),
        .O_START1  (o_s1),
        .O_START2  (o_s2),
        .O_BUSY    (o_busy),
        .DBG_STATE (dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- stimulus / log storage ----------------
    bit         vb_a [MAXN];
    bit         s1_a [MAXN];
    bit         s2_a [MAXN];
    bit         ci_a [MAXN];
    bit         tk_a [MAXN];
    logic [3:0] obs_a[MAXN];
    logic [3:0] exp_a[MAXN];
    logic [3:0] exp_q[$];

    int total = 0;
    int bad   = 0;
    int n     = 0;
    int idle_from;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // ---------------- stimulus builders ----------------
    task automatic clear_stim();
        for (int c = 0; c < MAXN; c++) begin
            vb_a[c] = 1'b0; s1_a[c] = 1'b0; s2_a[c] = 1'b0; ci_a[c] = 1'b0;
        end
    endtask

    // VBLANK high for 10 cycles out of every 100, rising at cycle 50 mod 100
    task automatic vb_periodic();
        for (int c = 0; c < MAXN; c++) vb_a[c] = ((c % 100) >= 50) && ((c % 100) < 60);
    endtask

    task automatic vb_random(input int len);
        int c = 0;
        while (c < len) begin
            int per = $urandom_range(4, 14);
            int hi  = $urandom_range(1, per - 2);
            for (int k = 0; k < hi && c + k < MAXN; k++) vb_a[c + k] = 1'b1;
            c += per;
        end
    endtask

    task automatic set_s1(input int from, input int len);
        for (int c = from; c < from + len && c < MAXN; c++) s1_a[c] = 1'b1;
    endtask
    task automatic set_s2(input int from, input int len);
        for (int c = from; c < from + len && c < MAXN; c++) s2_a[c] = 1'b1;
    endtask
    task automatic set_ci(input int from, input int len);
        for (int c = from; c < from + len && c < MAXN; c++) ci_a[c] = 1'b1;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input int c);
        vb = vb_a[c]; s1 = s1_a[c]; s2 = s2_a[c]; ci = ci_a[c];
    endtask

    // Reset, then play n_in cycles of stimulus, logging outputs mid-cycle.
    // Cycle 0 is the cycle in which reset is released.
    task automatic run_scn(input int n_in);
        n = n_in;
        rst = 1'b1;
        drive(0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < n; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1 drive(c);
            end
            @(negedge clk);
            obs_a[c] = {o_coin, o_s1, o_s2, o_busy};
        end
    endtask

    // ---------------- reference model ----------------
    // k-th frame tick strictly after cycle cur
    function automatic int kth_tick(input int cur, input int k);
        int cnt = 0;
        for (int c = cur + 1; c < n; c++) begin
            if (tk_a[c]) begin
                cnt++;
                if (cnt == k) return c;
            end
        end
        return BIG;
    endfunction

    task automatic fill(input int lo, input int hi, input logic [3:0] mask);
        for (int c = lo; c <= hi && c < n; c++) exp_a[c] = exp_a[c] | mask;
    endtask

    // A sequence launched from the idle cycle L: phases end on counted ticks.
    task automatic launch(input int l, input bit p2);
        int cur = l;
        int t;
        int coins = p2 ? 2 : 1;
        for (int i = 0; i < coins; i++) begin
            t = kth_tick(cur, C_F);
            fill(cur + 1, t, 4'b1000);
            cur = kth_tick(t, G_F);
        end
        t = kth_tick(cur, S_F);
        fill(cur + 1, t, p2 ? 4'b0010 : 4'b0100);
        cur = kth_tick(t, CD_F);
        fill(l + 1, cur, 4'b0001);
        idle_from = cur + 1;
    endtask

    task automatic model();
        bit slot_v = 1'b0;
        bit slot_p = 1'b0;
        idle_from = 0;
        for (int c = 0; c < n; c++) begin
            tk_a[c]  = vb_a[c] && !((c == 0) ? 1'b1 : vb_a[c - 1]);
            exp_a[c] = (c == 0) ? 4'b0000 : {ci_a[c - 1], 3'b000};
        end
        for (int c = 0; c < n; c++) begin
            bit r1 = 1'b0;
            bit r2 = 1'b0;
            if (c >= 1) begin
                r1 = s1_a[c - 1] && !((c == 1) ? 1'b1 : s1_a[c - 2]);
                r2 = s2_a[c - 1] && !((c == 1) ? 1'b1 : s2_a[c - 2]);
            end
            if (c >= idle_from) begin
                if (slot_v) begin
                    slot_v = 1'b0;
                    launch(c, slot_p);
                end else if (r1 || r2) begin
                    launch(c, r2);
                end
            end else if ((r1 || r2) && !slot_v) begin
                slot_v = 1'b1;
                slot_p = r2;
            end
        end
        for (int c = 0; c < n; c++) exp_q.push_back(exp_a[c]);
    endtask

    task automatic scoreboard(input string tag);
        model();
        for (int c = 0; c < n; c++) begin
            logic [3:0] e = exp_q.pop_front();
            check($sformatf("%s c%0d {coin,s1,s2,busy}", tag, c), 32'(obs_a[c]), 32'(e));
        end
    endtask

    // ---------------- log helpers ----------------
    function automatic int count_high(input int b);
        int k = 0;
        for (int c = 0; c < n; c++) if (obs_a[c][b]) k++;
        return k;
    endfunction

    function automatic int count_rises(input int b);
        int k = 0;
        for (int c = 1; c < n; c++) if (obs_a[c][b] && !obs_a[c - 1][b]) k++;
        return k;
    endfunction

    function automatic int first_high(input int b);
        for (int c = 0; c < n; c++) if (obs_a[c][b]) return c;
        return -1;
    endfunction

    function automatic int last_high(input int b);
        for (int c = n - 1; c >= 0; c--) if (obs_a[c][b]) return c;
        return -1;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        // 1P sequence, VBLANK every 100 cycles
        clear_stim(); vb_periodic(); set_s1(10, 20);
        run_scn(4800);
        scoreboard("p1");
        check("p1 coin_first", 32'(first_high(B_COIN)), 32'd12);
        check("p1 coin_pulses", 32'(count_rises(B_COIN)), 32'd1);
        check("p1 start1_len", 32'(count_high(B_S1)), 32'd400);
        check("p1 start2_len", 32'(count_high(B_S2)), 32'd0);
        check("p1 cooldown", 32'(last_high(B_BUSY) - last_high(B_S1)), 32'd3000);

        // 2P sequence
        clear_stim(); vb_periodic(); set_s2(10, 20);
        run_scn(6000);
        scoreboard("p2");
        check("p2 coin_pulses", 32'(count_rises(B_COIN)), 32'd2);
        check("p2 start2_len", 32'(count_high(B_S2)), 32'd400);
        check("p2 start1_len", 32'(count_high(B_S1)), 32'd0);

        // simultaneous requests resolve to 2P, no 1P follows
        clear_stim(); vb_periodic(); set_s1(10, 30); set_s2(10, 30);
        run_scn(6300);
        scoreboard("sim");
        check("sim coin_pulses", 32'(count_rises(B_COIN)), 32'd2);
        check("sim start1_len", 32'(count_high(B_S1)), 32'd0);
        check("sim start2_len", 32'(count_high(B_S2)), 32'd400);

        // pending slot: 1P parked in GAP, 2P during START_ON dropped
        clear_stim(); vb_periodic(); set_s1(10, 20); set_s1(600, 20); set_s2(1400, 20);
        run_scn(9400);
        scoreboard("pend");
        check("pend coin_pulses", 32'(count_rises(B_COIN)), 32'd2);
        check("pend start1_len", 32'(count_high(B_S1)), 32'd800);
        check("pend start2_len", 32'(count_high(B_S2)), 32'd0);
        check("pend idle_gap", 32'(obs_a[4551][B_BUSY]), 32'd0);
        check("pend relaunch", 32'(obs_a[4552][B_COIN]), 32'd1);
        check("pend busy_end", 32'(last_high(B_BUSY)), 32'd9150);

        // manual coin while idle
        clear_stim(); vb_periodic(); set_ci(100, 50);
        run_scn(300);
        scoreboard("man");
        check("man coin_len", 32'(count_high(B_COIN)), 32'd50);
        check("man busy_len", 32'(count_high(B_BUSY)), 32'd0);
        check("man coin_rise", 32'(first_high(B_COIN)), 32'd101);
        check("man coin_fall", 32'(last_high(B_COIN)), 32'd150);

        // reset during the second COIN_ON of a 2P run
        clear_stim(); vb_periodic(); set_s2(10, 20);
        run_scn(1300);
        scoreboard("rstA");
        check("rstA coin_before", 32'(obs_a[1299][B_COIN]), 32'd1);
        @(posedge clk);
        #3;
        s2  = 1'b1;
        rst = 1'b1;
        #1;
        check("rst async outs", 32'({o_coin, o_s1, o_s2, o_busy}), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rst held outs", 32'({o_coin, o_s1, o_s2, o_busy}), 32'd0);
            check("rst held state", 32'(dbg), 32'(IDLE));
        end
        // I_START2 held through reset, released, pressed again
        clear_stim(); vb_periodic(); set_s2(0, 300); set_s2(320, 20);
        run_scn(2000);
        scoreboard("rstB");
        check("rstB held_busy", 32'(obs_a[320][B_BUSY]), 32'd0);
        check("rstB coin_early", 32'(obs_a[321][B_COIN]), 32'd0);
        check("rstB coin_rise", 32'(obs_a[322][B_COIN]), 32'd1);

        // randomized traffic with short, irregular frames
        for (int r = 0; r < 3; r++) begin
            int c;
            clear_stim();
            vb_random(3000);
            c = $urandom_range(5, 50);
            while (c < 3000) begin
                int len = $urandom_range(1, 10);
                int sel = $urandom_range(0, 2);
                if (sel == 0 || sel == 2) set_s1(c, len);
                if (sel == 1 || sel == 2) set_s2(c, len);
                if ($urandom_range(0, 3) == 0) set_ci(c + $urandom_range(0, 60), $urandom_range(1, 8));
                c += len + $urandom_range(2, 400);
            end
            run_scn(3000);
            scoreboard($sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coin_start_seq.md
# coin_start_seq

Coin-and-start sequencer between the decoded player controls (keyboard/joystick start requests, manual coin) and the arcade core's active-low coin/start input bits. A single start request becomes a frame-timed sequence: one coin pulse (two for 2P), a settle gap, then the matching start pulse. The game therefore sees legal coin timing without a separate coin button. Timing is counted in video frames, derived from the core's vertical-blank output.

## Interface
Parameters:
- COIN_FRAMES, 4: frames O_COIN is held high per coin.
- GAP_FRAMES, 8: frames between coin pulses and before the start pulse.
- START_FRAMES, 4: frames O_START1/O_START2 is held high.
- COOLDOWN_FRAMES, 30: frames after the start pulse during which no new sequence launches.
- CNT_W, 8: frame-counter width; every *_FRAMES value must lie in 1..2^CNT_W-1.

Ports:
- CLK  in  1  system clock; only clock.
- RESET  in  1  asynchronous, active-high reset.
- I_VBLANK  in  1  core vertical blank, CLK domain; rising edge = frame tick.
- I_START1  in  1  1P start request, level, active-high.
- I_START2  in  1  2P start request, level, active-high.
- I_COIN  in  1  manual coin, level, active-high, OR'd into O_COIN.
- O_COIN  out  1  coin to core, active-high (top inverts).
- O_START1  out  1  1P start to core, active-high.
- O_START2  out  1  2P start to core, active-high.
- O_BUSY  out  1  high whenever state != IDLE.

## Operation
- Edge detect: registered copies of I_START1, I_START2 and I_VBLANK. Each reset value is 1, so inputs held through reset cannot fire. tick = I_VBLANK & ~vblank_q. req1 and req2 are rising edges of the start inputs.
- Arbitration: req1 and req2 in the same cycle resolves to player 2. One pending slot {valid, player}. In IDLE a request launches immediately. In any other state, the first request sets the slot and later requests are dropped until it clears.
- State machine and counter cnt (CNT_W bits); cnt is loaded on every state entry:
  - IDLE: on a request or valid pending slot, latch player, set coins_left = (player==2 ? 2 : 1), clear the slot, go to COIN_ON with cnt=COIN_FRAMES.
  - COIN_ON: on tick, decrement cnt. On tick with cnt==1, decrement coins_left and go to GAP with cnt=GAP_FRAMES.
  - GAP: on tick with cnt==1, go to COIN_ON if coins_left!=0, else START_ON with cnt=START_FRAMES.
  - START_ON: on tick with cnt==1, go to COOLDOWN with cnt=COOLDOWN_FRAMES.
  - COOLDOWN: on tick with cnt==1, go to IDLE. A valid pending slot launches on the following IDLE cycle.
- Outputs are registered and decoded from the next state:
  - O_COIN = (state==COIN_ON) | I_COIN_q. I_COIN_q is a single register stage.
  - O_START1 = START_ON & player==1; O_START2 = START_ON & player==2.
- Ticks arriving in IDLE are ignored. cnt never underflows; a tick at cnt==1 always transitions.

## Timing
- Reset (async assert): state=IDLE, cnt=0, pending cleared, all outputs 0. This applies mid-sequence too: any active coin/start pulse drops while RESET is high.
- Request to O_COIN high: 2 CLK cycles (edge register, then state/output register).
- The first COIN_ON frame is partial. O_COIN falls 1 cycle after the COIN_FRAMES-th tick following entry.
- A sequence spans exactly coins×(COIN_FRAMES+GAP_FRAMES)+START_FRAMES+COOLDOWN_FRAMES ticks, plus the partial first frame.
- The tick and a request arriving in the same cycle are independent; both take effect.

## Structure
- Package coin_seq_pkg holds:
  - the state enum: IDLE, COIN_ON, GAP, START_ON, COOLDOWN;
  - the player encoding: P1=1'b0, P2=1'b1;
  - default frame-count constants.
- One sub-module, frame_tick: the VBLANK rising-edge detector, reused by other cores for frame-timed logic. Edge detection for the start inputs stays inline.

## Test plan
- 1P sequence with defaults and VBLANK every 100 cycles: pulse I_START1.
  - O_COIN high 2 cycles later, for 4 ticks.
  - Gap of 8 ticks, then O_START1 high for 4 ticks.
  - O_BUSY falls 30 ticks after O_START1 falls; O_START2 stays 0 throughout.
- 2P sequence: pulse I_START2 → two O_COIN pulses of 4 ticks separated by 8 ticks, then O_START2 for 4 ticks.
- Simultaneous requests: I_START1 and I_START2 rise in the same cycle → the 2P sequence runs and no 1P sequence follows.
- Pending slot: pulse I_START1 during 1P GAP, then I_START2 during START_ON.
  - A second 1P sequence starts on the IDLE cycle after COOLDOWN.
  - The I_START2 request is dropped.
- Reset mid-operation: assert RESET during the second COIN_ON of a 2P run.
  - All outputs are 0 within the assertion; after release O_BUSY=0.
  - I_START2 held through reset produces no sequence until it is released and pressed again.
- Manual coin: I_COIN high for 50 cycles while IDLE → O_COIN follows it with 1-cycle delay and O_BUSY stays 0.
